// File: rtl/fetch_seq.sv
// fetch_seq: fetch/decode sequencer; T0-T1-T2[-T3]-EXEC with memRDY-stalled reads, execGO on EXEC entry.
// Stalls indefinitely on memRDY/execDONE; FETCH_TIMEOUT_EN adds a memRDY watchdog that parks in FAULT.
module fetch_seq #(
   parameter int AW      = 12,
   parameter int TIMEOUT = 15
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        start,
   input  logic [15:0] IR,
   input  logic        memRDY,
   input  logic        execDONE,
   output logic        irLD,
   output logic        irINR,
   output logic        irCLR,
   output logic        pcINR,
   output logic        pcCLR,
   output logic        arLD,
   output logic [1:0]  arSRC,
   output logic        memRD,
   output logic        execGO,
   output logic [2:0]  opcode,
   output logic        indir,
   output logic        busy,
   output logic        halted,
   output logic        fault
);

   typedef enum logic [3:0] {
      IDLE, CLEAR, T0, T1, T2, T3, EXEC, HALT, FAULT
   } state_t;

   localparam logic [15:0] HALT_INSN = 16'h7001;

   state_t     state, state_nx;
   logic       exec_first;
   logic       wait_expired;
   logic       in_read;
   logic [2:0] ir_op;
   logic       halt_ir;

   assign in_read = (state == T1) || (state == T3);
   assign ir_op   = IR[AW +: 3];
   assign halt_ir = (IR == HALT_INSN);

`ifdef FETCH_TIMEOUT_EN
   localparam logic FAULT_EN = 1'b1;
   logic [3:0] wait_cnt;

   // Fires on the TIMEOUT-th consecutive low memRDY cycle; a ready in that cycle still wins.
   assign wait_expired = in_read && !memRDY && (wait_cnt == 4'(TIMEOUT - 1));

   always_ff @(posedge CLK) begin
      if (RST) begin
         wait_cnt <= 4'd0;
      end else if (state_nx != state) begin
         wait_cnt <= 4'd0;
      end else if (in_read && !memRDY) begin
         wait_cnt <= wait_cnt + 4'd1;
      end
   end
`else
   localparam logic FAULT_EN = 1'b0;
   logic [3:0] timeout_unused;

   assign timeout_unused = 4'(TIMEOUT);
   assign wait_expired   = 1'b0;
`endif

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= IDLE;
         exec_first <= 1'b0;
         opcode     <= 3'd0;
         indir      <= 1'b0;
      end else begin
         state      <= state_nx;
         exec_first <= (state_nx == EXEC) && (state != EXEC);
         if (state == T2) begin
            opcode <= ir_op;
            indir  <= IR[15];
         end
      end
   end

   always_comb begin
      state_nx = state;
      irLD     = 1'b0;
      irINR    = 1'b0;
      irCLR    = 1'b0;
      pcINR    = 1'b0;
      pcCLR    = 1'b0;
      arLD     = 1'b0;
      arSRC    = 2'd0;
      memRD    = 1'b0;
      execGO   = 1'b0;
      halted   = 1'b0;
      fault    = 1'b0;

      case (state)
         IDLE: begin
            if (start) state_nx = CLEAR;
         end
         CLEAR: begin
            pcCLR    = 1'b1;
            irCLR    = 1'b1;
            state_nx = T0;
         end
         T0: begin
            arLD     = 1'b1;
            arSRC    = 2'd0;
            state_nx = T1;
         end
         T1: begin
            memRD = 1'b1;
            if (memRDY) begin
               irLD     = 1'b1;
               pcINR    = 1'b1;
               state_nx = T2;
            end else if (wait_expired) begin
               state_nx = FAULT;
            end
         end
         T2: begin
            if (halt_ir) begin
               state_nx = HALT;
            end else begin
               arLD  = 1'b1;
               arSRC = 2'd1;
               // Opcode 7 uses the operand field as an immediate, never as a pointer.
               if (IR[15] && (ir_op != 3'b111)) state_nx = T3;
               else                            state_nx = EXEC;
            end
         end
         T3: begin
            memRD = 1'b1;
            if (memRDY) begin
               arLD     = 1'b1;
               arSRC    = 2'd2;
               state_nx = EXEC;
            end else if (wait_expired) begin
               state_nx = FAULT;
            end
         end
         EXEC: begin
            execGO = exec_first;
            if (execDONE) state_nx = T0;
         end
         HALT: begin
            halted = 1'b1;
         end
         FAULT: begin
            fault = FAULT_EN;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   assign busy = (state != IDLE) && (state != HALT) && (state != FAULT);

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq: per-cycle strobe vectors checked against hand-derived tables.
module tb_fetch_seq;

   logic        CLK = 1'b0;
   logic        RST, start, memRDY, execDONE;
   logic [15:0] IR;
   logic        irLD, irINR, irCLR, pcINR, pcCLR, arLD, memRD, execGO;
   logic [1:0]  arSRC;
   logic [2:0]  opcode;
   logic        indir, busy, halted, fault;

   int n_chk  = 0;
   int n_fail = 0;

   fetch_seq #(.AW(12), .TIMEOUT(15)) dut (
      .CLK(CLK), .RST(RST), .start(start), .IR(IR), .memRDY(memRDY), .execDONE(execDONE),
      .irLD(irLD), .irINR(irINR), .irCLR(irCLR), .pcINR(pcINR), .pcCLR(pcCLR),
      .arLD(arLD), .arSRC(arSRC), .memRD(memRD), .execGO(execGO),
      .opcode(opcode), .indir(indir), .busy(busy), .halted(halted), .fault(fault)
   );

   always #5 CLK = ~CLK;

   // {irLD,irINR,irCLR,pcINR,pcCLR,arLD,arSRC[1:0],memRD,execGO,busy,halted,fault}
   wire [12:0] outs = {irLD, irINR, irCLR, pcINR, pcCLR, arLD, arSRC, memRD, execGO, busy, halted, fault};

   localparam logic [12:0] B_IRLD  = 13'h1000;
   localparam logic [12:0] B_IRCLR = 13'h0400;
   localparam logic [12:0] B_PCINR = 13'h0200;
   localparam logic [12:0] B_PCCLR = 13'h0100;
   localparam logic [12:0] B_ARLD  = 13'h0080;
   localparam logic [12:0] B_SRC1  = 13'h0020;
   localparam logic [12:0] B_SRC2  = 13'h0040;
   localparam logic [12:0] B_MEMRD = 13'h0010;
   localparam logic [12:0] B_GO    = 13'h0008;
   localparam logic [12:0] B_BUSY  = 13'h0004;
   localparam logic [12:0] B_HALT  = 13'h0002;
   localparam logic [12:0] B_FAULT = 13'h0001;

   localparam logic [12:0] O_IDLE = 13'h0000;
   localparam logic [12:0] O_CLR  = B_PCCLR | B_IRCLR | B_BUSY;
   localparam logic [12:0] O_T0   = B_ARLD | B_BUSY;
   localparam logic [12:0] O_RDW  = B_MEMRD | B_BUSY;
   localparam logic [12:0] O_T1R  = B_IRLD | B_PCINR | B_MEMRD | B_BUSY;
   localparam logic [12:0] O_T2A  = B_ARLD | B_SRC1 | B_BUSY;
   localparam logic [12:0] O_T3R  = B_ARLD | B_SRC2 | B_MEMRD | B_BUSY;
   localparam logic [12:0] O_EXG  = B_GO | B_BUSY;
   localparam logic [12:0] O_BUSY = B_BUSY;
   localparam logic [12:0] O_HLT  = B_HALT;
   localparam logic [12:0] O_FLT  = B_FAULT;

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RST      = 1'b1;
      start    = 1'b0;
      memRDY   = 1'b0;
      execDONE = 1'b0;
      cyc();
      RST = 1'b0;
   endtask

   task automatic test_reset();
      IR = 16'h0000;
      do_reset();
      #1;
      n_chk++; if (outs !== O_IDLE) begin n_fail++; $display("FAIL reset_outs: got %h want %h", outs, O_IDLE); end
      n_chk++; if (opcode !== 3'd0) begin n_fail++; $display("FAIL reset_opcode: got %0d want 0", opcode); end
      n_chk++; if (indir !== 1'b0) begin n_fail++; $display("FAIL reset_indir: got %0b want 0", indir); end
   endtask

   task automatic test_direct();
      logic [12:0] exp[6];
      exp = '{O_CLR, O_T0, O_T1R, O_T2A, O_EXG, O_T0};
      do_reset();
      IR = 16'h1005; memRDY = 1'b1; start = 1'b1;
      #1;
      n_chk++; if (outs !== O_IDLE) begin n_fail++; $display("FAIL direct_idle_start: got %h want %h", outs, O_IDLE); end
      cyc();
      start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         execDONE = (i == 4);
         #1;
         n_chk++; if (outs !== exp[i]) begin n_fail++; $display("FAIL direct_step%0d: got %h want %h", i, outs, exp[i]); end
         if (i == 4) begin
            n_chk++; if (opcode !== 3'd1) begin n_fail++; $display("FAIL direct_opcode: got %0d want 1", opcode); end
            n_chk++; if (indir !== 1'b0) begin n_fail++; $display("FAIL direct_indir: got %0b want 0", indir); end
         end
         cyc();
      end
      execDONE = 1'b0;
   endtask

   task automatic test_indirect();
      logic [12:0] exp[9];
      logic        rdy[9];
      logic        done[9];
      logic [12:0] exp7[6];
      exp  = '{O_CLR, O_T0, O_T1R, O_T2A, O_RDW, O_T3R, O_EXG, O_BUSY, O_T0};
      rdy  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      done = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      do_reset();
      IR = 16'h9020; start = 1'b1;
      cyc();
      start = 1'b0;
      for (int i = 0; i < 9; i++) begin
         memRDY = rdy[i]; execDONE = done[i];
         #1;
         n_chk++; if (outs !== exp[i]) begin n_fail++; $display("FAIL indirect_step%0d: got %h want %h", i, outs, exp[i]); end
         if (i == 6) begin
            n_chk++; if (indir !== 1'b1) begin n_fail++; $display("FAIL indirect_indir: got %0b want 1", indir); end
            n_chk++; if (opcode !== 3'd1) begin n_fail++; $display("FAIL indirect_opcode: got %0d want 1", opcode); end
         end
         cyc();
      end
      // bit15 set with opcode 7 skips T3
      exp7 = '{O_CLR, O_T0, O_T1R, O_T2A, O_EXG, O_T0};
      do_reset();
      IR = 16'hF123; memRDY = 1'b1; start = 1'b1;
      cyc();
      start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         execDONE = (i == 4);
         #1;
         n_chk++; if (outs !== exp7[i]) begin n_fail++; $display("FAIL op7_step%0d: got %h want %h", i, outs, exp7[i]); end
         if (i == 4) begin
            n_chk++; if ({indir, opcode} !== 4'hF) begin n_fail++; $display("FAIL op7_latch: got %h want f", {indir, opcode}); end
         end
         cyc();
      end
      execDONE = 1'b0;
   endtask

   task automatic test_wait_states();
      int rd_cnt = 0, ld_cnt = 0, inr_cnt = 0;
      do_reset();
      IR = 16'h2003; start = 1'b1;
      cyc();
      start = 1'b0;
      cyc();
      cyc();
      for (int i = 0; i < 5; i++) begin
         memRDY = (i == 4);
         #1;
         n_chk++; if (outs !== ((i == 4) ? O_T1R : O_RDW)) begin n_fail++; $display("FAIL wait_step%0d: got %h", i, outs); end
         rd_cnt += int'(memRD); ld_cnt += int'(irLD); inr_cnt += int'(pcINR);
         cyc();
      end
      memRDY = 1'b0;
      #1;
      rd_cnt += int'(memRD); ld_cnt += int'(irLD); inr_cnt += int'(pcINR);
      n_chk++; if (outs !== O_T2A) begin n_fail++; $display("FAIL wait_t2: got %h want %h", outs, O_T2A); end
      n_chk++; if (rd_cnt != 5) begin n_fail++; $display("FAIL wait_memrd_cycles: got %0d want 5", rd_cnt); end
      n_chk++; if (ld_cnt != 1 || inr_cnt != 1) begin n_fail++; $display("FAIL wait_pulses: irLD %0d pcINR %0d want 1 1", ld_cnt, inr_cnt); end
   endtask

   task automatic test_halt();
      logic [12:0] exp[5];
      exp = '{O_CLR, O_T0, O_T1R, O_BUSY, O_HLT};
      do_reset();
      IR = 16'h7001; memRDY = 1'b1; start = 1'b1;
      cyc();
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         n_chk++; if (outs !== exp[i]) begin n_fail++; $display("FAIL halt_step%0d: got %h want %h", i, outs, exp[i]); end
         cyc();
      end
      n_chk++; if ({indir, opcode} !== 4'h7) begin n_fail++; $display("FAIL halt_latch: got %h want 7", {indir, opcode}); end
      start = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         n_chk++; if (outs !== O_HLT) begin n_fail++; $display("FAIL halt_start_ignored%0d: got %h want %h", i, outs, O_HLT); end
      end
      RST = 1'b1;
      cyc();
      RST = 1'b0; start = 1'b0;
      #1;
      n_chk++; if (outs !== O_IDLE) begin n_fail++; $display("FAIL halt_reset: got %h want %h", outs, O_IDLE); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      IR = 16'h1005; memRDY = 1'b0; start = 1'b1;
      cyc();
      start = 1'b0;
      cyc();
      cyc();
      #1;
      n_chk++; if (outs !== O_RDW) begin n_fail++; $display("FAIL mid_t1_pre: got %h want %h", outs, O_RDW); end
      RST = 1'b1;
      cyc();
      RST = 1'b0; execDONE = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_chk++; if (outs !== O_IDLE) begin n_fail++; $display("FAIL mid_t1_post%0d: got %h want %h", i, outs, O_IDLE); end
         cyc();
      end
      execDONE = 1'b0; memRDY = 1'b1; start = 1'b1;
      cyc();
      start = 1'b0;
      repeat (4) cyc();
      #1;
      n_chk++; if (outs !== O_EXG || opcode !== 3'd1) begin n_fail++; $display("FAIL mid_exec_pre: got %h/%0d want %h/1", outs, opcode, O_EXG); end
      RST = 1'b1;
      cyc();
      RST = 1'b0; execDONE = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_chk++; if (outs !== O_IDLE || opcode !== 3'd0) begin n_fail++; $display("FAIL mid_exec_post%0d: got %h/%0d want %h/0", i, outs, opcode, O_IDLE); end
         cyc();
      end
      execDONE = 1'b0;
   endtask

   task automatic test_timeout();
      do_reset();
      IR = 16'h1005; memRDY = 1'b0; start = 1'b1;
      cyc();
      start = 1'b0;
      cyc();
      cyc();
`ifdef FETCH_TIMEOUT_EN
      for (int i = 0; i < 15; i++) begin
         #1;
         n_chk++; if (outs !== O_RDW) begin n_fail++; $display("FAIL tmo_wait%0d: got %h want %h", i, outs, O_RDW); end
         cyc();
      end
      #1;
      n_chk++; if (outs !== O_FLT) begin n_fail++; $display("FAIL tmo_fault: got %h want %h", outs, O_FLT); end
      memRDY = 1'b1;
      cyc();
      n_chk++; if (outs !== O_FLT) begin n_fail++; $display("FAIL tmo_fault_hold: got %h want %h", outs, O_FLT); end
      do_reset();
      start = 1'b1;
      cyc();
      start = 1'b0;
      cyc();
      cyc();
      for (int i = 0; i < 14; i++) begin
         #1;
         n_chk++; if (outs !== O_RDW) begin n_fail++; $display("FAIL tmo_edge_wait%0d: got %h want %h", i, outs, O_RDW); end
         cyc();
      end
      memRDY = 1'b1;
      #1;
      n_chk++; if (outs !== O_T1R) begin n_fail++; $display("FAIL tmo_edge_ready: got %h want %h", outs, O_T1R); end
      cyc();
      n_chk++; if (outs !== O_T2A) begin n_fail++; $display("FAIL tmo_edge_t2: got %h want %h", outs, O_T2A); end
`else
      for (int i = 0; i < 20; i++) begin
         #1;
         n_chk++; if (outs !== O_RDW) begin n_fail++; $display("FAIL nowdog_wait%0d: got %h want %h", i, outs, O_RDW); end
         cyc();
      end
      memRDY = 1'b1;
      #1;
      n_chk++; if (outs !== O_T1R) begin n_fail++; $display("FAIL nowdog_ready: got %h want %h", outs, O_T1R); end
      cyc();
      n_chk++; if (outs !== O_T2A) begin n_fail++; $display("FAIL nowdog_t2: got %h want %h", outs, O_T2A); end
`endif
      do_reset();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      RST = 1'b1; start = 1'b0; memRDY = 1'b0; execDONE = 1'b0; IR = 16'h0000;
      test_reset();
      test_direct();
      test_indirect();
      test_wait_states();
      test_halt();
      test_reset_mid();
      test_timeout();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
